// File: rtl/fast_core_i_prefetch_pkg.sv
// rtl/fast_core_i_prefetch_pkg.sv - shared types and constants for the FP51 fast-core instruction prefetch
package fast_core_prefetch_pkg;

  typedef enum logic {
    S_HOLD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Each fetch port returns one 24-bit word covering three consecutive code bytes.
  localparam int BYTES_PER_PORT = 3;

  // Byte k of a fetch word (address base+k) sits in bits [8k+7:8k].
  typedef logic [8*BYTES_PER_PORT-1:0] fetch_word_t;

endpackage

// File: rtl/fast_core_i_prefetch_if.sv
// rtl/fast_core_i_prefetch_if.sv - multi-port code-memory fetch bus between prefetch unit and code memory
interface fast_core_i_prefetch_if
  import fast_core_prefetch_pkg::*;
#(
  parameter int PC_BITWIDTH = 16,
  parameter int NUM_PORTS   = 2
);

  logic        [NUM_PORTS-1:0]                  re;
  logic        [NUM_PORTS-1:0][PC_BITWIDTH-1:0] fetch_addr;
  fetch_word_t [NUM_PORTS-1:0]                  rd_data;

  modport master (
    output re,
    output fetch_addr,
    input  rd_data
  );

  modport slave (
    input  re,
    input  fetch_addr,
    output rd_data
  );

endinterface

// File: rtl/fast_core_i_prefetch_byte_queue.sv
// rtl/fast_core_i_prefetch_byte_queue.sv - circular byte queue with wide push and 1..3 byte pop
module fast_core_byte_queue
  import fast_core_prefetch_pkg::*;
#(
  parameter  int QUEUE_DEPTH = 16,
  parameter  int PUSH_BYTES  = 6,
  localparam int PW          = $clog2(QUEUE_DEPTH),
  localparam int LW          = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_flush,
  input  logic                    i_push,
  input  logic [8*PUSH_BYTES-1:0] i_push_data,
  input  logic                    i_pop,
  input  logic [1:0]              i_pop_len,
  output logic [LW-1:0]           o_level,
  output fetch_word_t             o_window
);

  logic [7:0]    r_mem [QUEUE_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [LW-1:0] w_push_cnt;
  logic [LW-1:0] w_pop_cnt;

  assign w_push_cnt = i_push ? LW'(PUSH_BYTES) : '0;
  assign w_pop_cnt  = i_pop  ? LW'(i_pop_len)  : '0;

  // Storage write: a push lays its bytes in order starting at the write pointer.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      for (int k = 0; k < PUSH_BYTES; k++) begin
        r_mem[r_wr_ptr + PW'(k)] <= i_push_data[8*k +: 8];
      end
    end
  end

  // Pointer and level update; flush wins over a simultaneous push or pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(PUSH_BYTES);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(i_pop_len);
      end
      r_level <= r_level + w_push_cnt - w_pop_cnt;
    end
  end

  assign o_level  = r_level;
  assign o_window = {r_mem[r_rd_ptr + PW'(2)], r_mem[r_rd_ptr + PW'(1)], r_mem[r_rd_ptr]};

endmodule

// File: rtl/fast_core_i_prefetch.sv
// rtl/fast_core_i_prefetch.sv - N-port instruction prefetch top; optional FAST_CORE_PREFETCH_STATS_EN adds stall/redirect counters
module fast_core_i_prefetch
  import fast_core_prefetch_pkg::*;
#(
  parameter  int PC_BITWIDTH = 16,
  parameter  int NUM_PORTS   = 2,
  parameter  int QUEUE_DEPTH = 16,
  localparam int LW          = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_sync_reset,
  input  logic                   i_redirect,
  input  logic [PC_BITWIDTH-1:0] i_redirect_pc,
  input  logic                   i_consume,
  input  logic [1:0]             i_consume_len,
  fast_core_i_prefetch_if.master fetch_bus,
  output logic                   o_instr_valid,
  output fetch_word_t            o_instr_window,
  output logic [PC_BITWIDTH-1:0] o_instr_pc,
  output logic [LW-1:0]          o_queue_level
`ifdef FAST_CORE_PREFETCH_STATS_EN
  ,
  output logic [31:0]            o_stat_stall_cnt,
  output logic [31:0]            o_stat_redirect_cnt
`endif
);

  localparam int FETCH_BYTES = BYTES_PER_PORT * NUM_PORTS;

  state_t                   r_state;
  state_t                   w_state_next;
  logic                     r_inflight;
  logic [PC_BITWIDTH-1:0]   r_fetch_base;
  logic [PC_BITWIDTH-1:0]   r_instr_pc;
  logic [PC_BITWIDTH-1:0]   w_base;
  logic                     w_redirect;
  logic                     w_issue;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_flush;
  logic                     w_instr_valid;
  logic [LW-1:0]            w_level;
  fetch_word_t              w_window;
  logic [8*FETCH_BYTES-1:0] w_push_data;
  int                       w_level_eff;
  int                       w_inflight_eff;

  // A sync_reset in the same cycle cancels the redirect entirely.
  assign w_redirect = i_redirect && !i_sync_reset;
  assign w_base     = w_redirect ? i_redirect_pc : r_fetch_base;
  assign w_flush    = i_sync_reset || w_redirect;

  // Data returning in a redirect cycle belongs to the old stream and is dropped.
  assign w_push        = r_inflight && !w_redirect;
  assign w_instr_valid = (w_level >= LW'(3));
  assign w_pop         = i_consume && w_instr_valid && (i_consume_len != 2'd0) && !w_redirect;
  assign w_push_data   = fetch_bus.rd_data;

  // Next state and issue decision; a redirect sees an empty queue with nothing in flight.
  always_comb begin
    w_state_next   = r_state;
    w_level_eff    = int'(w_level);
    w_inflight_eff = r_inflight ? FETCH_BYTES : 0;
    w_issue        = 1'b0;
    if (w_redirect) begin
      w_level_eff    = 0;
      w_inflight_eff = 0;
    end
    if (!i_sync_reset && ((r_state == S_RUN) || w_redirect)) begin
      w_issue = ((QUEUE_DEPTH - w_level_eff - w_inflight_eff) >= FETCH_BYTES);
    end
    if (i_sync_reset) begin
      w_state_next = S_HOLD;
    end else begin
      case (r_state)
        S_HOLD:  if (w_redirect) w_state_next = S_RUN;
        S_RUN:   w_state_next = S_RUN;
        default: w_state_next = S_HOLD;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_HOLD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // In-flight flag: marks that the ports return data in the next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight <= 1'b0;
    end else if (i_sync_reset) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
    end
  end

  // Fetch base advances by a full issue group; it survives sync_reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_base <= '0;
    end else if (w_issue) begin
      r_fetch_base <= w_base + PC_BITWIDTH'(FETCH_BYTES);
    end
  end

  // Instruction PC tracks the queue read pointer in code-address space.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr_pc <= '0;
    end else if (i_sync_reset) begin
      r_instr_pc <= '0;
    end else if (w_redirect) begin
      r_instr_pc <= i_redirect_pc;
    end else if (w_pop) begin
      r_instr_pc <= r_instr_pc + PC_BITWIDTH'(i_consume_len);
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign fetch_bus.fetch_addr[g] = w_base + PC_BITWIDTH'(BYTES_PER_PORT * g);
  end
  assign fetch_bus.re = {NUM_PORTS{w_issue}};

  fast_core_byte_queue #(
    .QUEUE_DEPTH (QUEUE_DEPTH),
    .PUSH_BYTES  (FETCH_BYTES)
  ) u_queue (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_flush     (w_flush),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_pop_len   (i_consume_len),
    .o_level     (w_level),
    .o_window    (w_window)
  );

  assign o_instr_valid  = w_instr_valid;
  assign o_instr_window = w_instr_valid ? w_window : '0;
  assign o_instr_pc     = r_instr_pc;
  assign o_queue_level  = w_level;

`ifdef FAST_CORE_PREFETCH_STATS_EN
  logic [31:0] r_stat_stall_cnt;
  logic [31:0] r_stat_redirect_cnt;

  // Saturating counters of starved run cycles and accepted redirects.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_stall_cnt    <= '0;
      r_stat_redirect_cnt <= '0;
    end else if (i_sync_reset) begin
      r_stat_stall_cnt    <= '0;
      r_stat_redirect_cnt <= '0;
    end else begin
      if ((r_state == S_RUN) && !w_instr_valid && (r_stat_stall_cnt != '1)) begin
        r_stat_stall_cnt <= r_stat_stall_cnt + 32'd1;
      end
      if (w_redirect && (r_stat_redirect_cnt != '1)) begin
        r_stat_redirect_cnt <= r_stat_redirect_cnt + 32'd1;
      end
    end
  end

  assign o_stat_stall_cnt    = r_stat_stall_cnt;
  assign o_stat_redirect_cnt = r_stat_redirect_cnt;
`endif

endmodule
